raster_sched: RTL and testbench
===============================

Name: raster_sched

Overview:
- Central raster timing and sequencing controller for the VGA donut design; runs on the 48 MHz pixel clock.
- Generates the h/v counters, registered syncs, display-active flag and the frame counter.
- Issues a per-line start pulse a programmable number of cycles ahead of each visible line, so the per-line renderer can preload (divider lead time).
- Arbitrates one parameter-update grant per frame, during vblank only, so rotation state never changes mid-frame.

Parameters:
- H_DISPLAY, 1220, visible clocks per line
- H_FRONT_PORCH, 31, clocks from end of display to hsync start
- H_SYNC_PULSE, 183, hsync width in clocks
- H_TOTAL, 1525, clocks per line; independent of the sum of the other H parameters
- V_DISPLAY, 480, visible lines
- V_FRONT_PORCH, 10, lines from end of display to vsync start
- V_SYNC_PULSE, 2, vsync width in lines
- V_TOTAL, 525, lines per frame
- LINE_LEAD, 16, clocks of lead before line start; legal range 1..H_TOTAL-H_DISPLAY-1

Ports:
- clk48  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  when 1, frame counter holds its value
- upd_req  in  1  level request from the parameter updater
- h_count  out  11  horizontal counter
- v_count  out  10  vertical counter
- display_active  out  1  combinational: h_count<H_DISPLAY and v_count<V_DISPLAY
- hsync  out  1  registered, active-low
- vsync  out  1  registered, active-low
- frame  out  8  frame counter
- frame_start  out  1  one-cycle pulse
- line_start  out  1  one-cycle pulse
- line_y  out  10  index of the line announced by line_start
- upd_window  out  1  high while the update window is OPEN
- upd_ack  out  1  one-cycle grant pulse

Behaviour:
- Reset values (asynchronous, active-low):
  - h_count=0, v_count=0, frame=0, line_y=0.
  - hsync=1, vsync=1.
  - frame_start=0, line_start=0, upd_ack=0.
  - FSM=IDLE, so upd_window=0.
- Counters:
  - h_count wraps H_TOTAL-1 -> 0.
  - On that wrap, v_count increments, wrapping V_TOTAL-1 -> 0.
  - On the frame wrap, frame increments mod 256 unless freeze=1.
- Syncs are registered and lag the counters by 1 cycle:
  - hsync <= ~(H_DISPLAY+H_FRONT_PORCH <= h_count < H_DISPLAY+H_FRONT_PORCH+H_SYNC_PULSE).
  - vsync uses the same rule on v_count with the V parameters.
- frame_start: registered. High exactly in the cycle where h_count=0 and v_count=0, but not in the first cycle after reset release.
- line_start:
  - Let LS = H_TOTAL-LINE_LEAD.
  - Let ny = (v_count==V_TOTAL-1) ? 0 : v_count+1.
  - line_start is high in the cycle where h_count==LS, provided ny<V_DISPLAY.
  - line_y updates to ny in that same cycle and holds otherwise.
  - Result: exactly V_DISPLAY pulses per frame, with line_y = 0..V_DISPLAY-1 in order.
  - The pulse for line 0 occurs on line V_TOTAL-1.
- Update FSM, registered outputs:
  - IDLE -> OPEN at the cycle h_count==0, v_count==V_DISPLAY.
  - OPEN with upd_req=1 -> CLOSED. upd_ack=1 for exactly that one cycle; this is the ack-cycle.
  - OPEN -> CLOSED without ack at the cycle v_count==V_TOTAL-1, h_count==LS-1, i.e. before line 0's line_start.
  - CLOSED -> IDLE at frame_start.
  - upd_window=1 iff state==OPEN.
  - Maximum one ack per frame. upd_req outside OPEN is ignored (no queuing).
  - The requester must drop upd_req after ack. A request still high in a later frame is granted again at the next window open.
- Simultaneous events:
  - upd_req rising on the exact window-close cycle: the close wins, no ack.
  - upd_req already high when OPEN is entered: ack on the first OPEN cycle, i.e. the cycle after entry.
- Reset mid-frame: immediate return to the reset state; no pulse is emitted on release.
- freeze affects only frame. Counters, syncs, pulses and the FSM keep running.

Test Plan:
- Reset release, run 2 frames:
  - 2*525*1525 cycles per 2 frames; frame=2.
  - frame_start pulses at cycles 800625 and 1601250 after release.
  - hsync low for 183 clocks starting 1 cycle after h_count=1251.
  - vsync low on lines 490-491, plus 1-cycle lag.
- line_start over one frame:
  - 480 pulses.
  - First pulse at v_count=524, h_count=1509, line_y=0.
  - Last pulse at v_count=478, h_count=1509, line_y=479.
  - No pulse on lines 479-523.
- upd_req held 1 from reset:
  - Exactly one upd_ack per frame, each on the cycle after h=0, v=480.
  - upd_window high for 1 cycle only.
- upd_req pulsed at v_count=300: no ack, no window.
- upd_req raised at v=524, h=1508 (the close cycle): no ack; FSM CLOSED.
- upd_req raised at v=524, h=1507: ack at h=1508.
- freeze=1 across 3 frame wraps: frame unchanged, frame_start still pulses 3 times.
- Assert rst_n at v=200: all outputs return to reset values asynchronously; release resumes from 0,0.

Source files
------------

// File: rtl/raster_sched.sv
// rtl/raster_sched.sv - raster timing, line pre-start and per-frame update arbitration
//
// Purpose: free-running h/v raster counters with registered syncs, a frame
// counter, a line_start pulse issued LINE_LEAD clocks ahead of each visible
// line, and a once-per-frame parameter-update grant confined to vblank.
//
// Ports:
//   clk48          in   pixel clock
//   rst_n          in   asynchronous active-low reset
//   freeze         in   hold the frame counter
//   upd_req        in   level request from the parameter updater
//   h_count        out  horizontal counter (0..H_TOTAL-1)
//   v_count        out  vertical counter (0..V_TOTAL-1)
//   display_active out  h_count/v_count inside the visible area
//   hsync, vsync   out  registered, active-low syncs (one clock behind counters)
//   frame          out  frame counter, mod 256
//   frame_start    out  pulse while counters read 0,0
//   line_start     out  pulse announcing line_y, LINE_LEAD clocks early
//   line_y         out  line announced by the latest line_start
//   upd_window     out  update window open
//   upd_ack        out  one-cycle update grant
module raster_sched #(
  parameter int H_DISPLAY     = 1220,
  parameter int H_FRONT_PORCH = 31,
  parameter int H_SYNC_PULSE  = 183,
  parameter int H_TOTAL       = 1525,
  parameter int V_DISPLAY     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_TOTAL       = 525,
  parameter int LINE_LEAD     = 16
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        upd_req,
  output logic [10:0] h_count,
  output logic [9:0]  v_count,
  output logic        display_active,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  frame,
  output logic        frame_start,
  output logic        line_start,
  output logic [9:0]  line_y,
  output logic        upd_window,
  output logic        upd_ack
);

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_DISP   = 11'(H_DISPLAY);
  localparam logic [10:0] HS_BEG   = 11'(H_DISPLAY + H_FRONT_PORCH);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE);
  // line_start is registered, so it is decided one clock before h_count==LS.
  localparam logic [10:0] LS_M1    = 11'(H_TOTAL - LINE_LEAD - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_DISP   = 10'(V_DISPLAY);
  localparam logic [9:0]  V_DISP_M1 = 10'(V_DISPLAY - 1);
  localparam logic [9:0]  VS_BEG   = 10'(V_DISPLAY + V_FRONT_PORCH);
  localparam logic [9:0]  VS_END   = 10'(V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OPEN   = 2'd1;
  localparam logic [1:0] ST_CLOSED = 2'd2;

  logic [10:0] h_count_q, h_count_d;
  logic [9:0]  v_count_q, v_count_d;
  logic [7:0]  frame_q, frame_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic        line_start_q, line_start_d;
  logic [9:0]  line_y_q, line_y_d;
  logic [1:0]  state_q, state_d;
  logic        upd_ack_q, upd_ack_d;

  logic        h_wrap;
  logic        v_wrap;
  logic [9:0]  next_y;

  always_comb begin
    h_wrap = (h_count_q == H_LAST);
    v_wrap = (v_count_q == V_LAST);
    next_y = v_wrap ? 10'd0 : v_count_q + 10'd1;

    h_count_d = h_wrap ? 11'd0 : h_count_q + 11'd1;
    v_count_d = v_count_q;
    if (h_wrap) begin
      v_count_d = v_wrap ? 10'd0 : v_count_q + 10'd1;
    end

    frame_d = frame_q;
    if (h_wrap && v_wrap && !freeze) begin
      frame_d = frame_q + 8'd1;
    end

    hsync_d = !((h_count_q >= HS_BEG) && (h_count_q < HS_END));
    vsync_d = !((v_count_q >= VS_BEG) && (v_count_q < VS_END));

    // Decided on the last clock of the frame so the pulse lines up with 0,0.
    frame_start_d = h_wrap && v_wrap;

    // The line being announced is the one after the current line, so line 0
    // is announced during the final line of the previous frame.
    line_start_d = (h_count_q == LS_M1) && (next_y < V_DISP);
    line_y_d     = line_start_d ? next_y : line_y_q;

    state_d   = state_q;
    upd_ack_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Open so that the window is visible when counters read 0,V_DISPLAY.
        if (h_wrap && (v_count_q == V_DISP_M1)) begin
          state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        // Closing takes priority over a request arriving on the same clock,
        // keeping line 0's preload free of a parameter change.
        if (v_wrap && (h_count_q == LS_M1)) begin
          state_d = ST_CLOSED;
        end else if (upd_req) begin
          state_d   = ST_CLOSED;
          upd_ack_d = 1'b1;
        end
      end
      ST_CLOSED: begin
        if (frame_start_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      frame_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      line_y_q      <= '0;
      state_q       <= ST_IDLE;
      upd_ack_q     <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_q       <= frame_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      line_y_q      <= line_y_d;
      state_q       <= state_d;
      upd_ack_q     <= upd_ack_d;
    end
  end

  assign h_count        = h_count_q;
  assign v_count        = v_count_q;
  assign display_active = (h_count_q < H_DISP) && (v_count_q < V_DISP);
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign frame          = frame_q;
  assign frame_start    = frame_start_q;
  assign line_start     = line_start_q;
  assign line_y         = line_y_q;
  assign upd_window     = (state_q == ST_OPEN);
  assign upd_ack        = upd_ack_q;

endmodule

// File: tb/tb_raster_sched.sv
// tb/tb_raster_sched.sv - scoreboard bench for raster_sched on a reduced raster
module tb_raster_sched;

  localparam int HD = 20, HFP = 3, HSP = 4, HT = 32;
  localparam int VD = 12, VFP = 2, VSP = 2, VT = 20;
  localparam int LEAD = 4;
  localparam int LS = HT - LEAD;
  localparam int FT = HT * VT;

  logic        clk48 = 1'b0;
  logic        rst_n = 1'b1;
  logic        freeze = 1'b0;
  logic        upd_req = 1'b0;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        display_active, hsync, vsync;
  logic [7:0]  frame;
  logic        frame_start, line_start;
  logic [9:0]  line_y;
  logic        upd_window, upd_ack;

  raster_sched #(
    .H_DISPLAY(HD), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_TOTAL(VT),
    .LINE_LEAD(LEAD)
  ) dut (
    .clk48(clk48), .rst_n(rst_n), .freeze(freeze), .upd_req(upd_req),
    .h_count(h_count), .v_count(v_count), .display_active(display_active),
    .hsync(hsync), .vsync(vsync), .frame(frame), .frame_start(frame_start),
    .line_start(line_start), .line_y(line_y), .upd_window(upd_window),
    .upd_ack(upd_ack)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    int kind;   // 1 frame_start, 2 line_start, 3 upd_ack
    int t;
    int y;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  t = 0;
  int  exp_frame = 0;
  int  win_mode = 0;  // 0 no requests, 1 request held, 2 directed checks only

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  function automatic void push_ev(input int kind, input int tt, input int y);
    ev_t e;
    int  i;
    e.kind = kind;
    e.t    = tt;
    e.y    = y;
    i = sb.size();
    while (i > 0 && sb[i-1].t > tt) i--;
    sb.insert(i, e);
  endfunction

  // Expected pulses straight from the raster timing rules, line by line.
  task automatic gen_events(input int nlines, input bit acks);
    for (int l = 0; l < nlines; l++) begin
      int lv, ny;
      lv = l % VT;
      if (l > 0 && lv == 0) push_ev(1, l * HT, 0);
      if (acks && lv == VD) push_ev(3, l * HT + 1, 0);
      ny = (lv == VT - 1) ? 0 : lv + 1;
      if (ny < VD) push_ev(2, l * HT + LS, ny);
    end
  endtask

  task automatic take_ev(input int kind, input int y);
    ev_t e;
    if (sb.size() == 0) begin
      chk_eq("unexpected_ev", kind, 0);
    end else begin
      e = sb.pop_front();
      chk_eq("ev_kind", kind, e.kind);
      chk_eq("ev_time", t, e.t);
      if (kind == 2) chk_eq("line_y", y, e.y);
    end
  endtask

  task automatic check_cycle();
    int eh, ev, ph, pv;
    bit ehs, evs, ewin;
    eh = t % HT;
    ev = (t / HT) % VT;
    ehs = 1'b1;
    evs = 1'b1;
    if (t > 0) begin
      ph = (t - 1) % HT;
      pv = ((t - 1) / HT) % VT;
      ehs = !(ph >= HD + HFP && ph < HD + HFP + HSP);
      evs = !(pv >= VD + VFP && pv < VD + VFP + VSP);
    end
    chk_eq("h_count", h_count, eh);
    chk_eq("v_count", v_count, ev);
    chk_eq("display_active", display_active, (eh < HD && ev < VD));
    chk_eq("hsync", hsync, ehs);
    chk_eq("vsync", vsync, evs);
    chk_eq("frame", frame, exp_frame);
    if (win_mode != 2) begin
      if (win_mode == 0) ewin = (ev >= VD) && !(ev == VT - 1 && eh >= LS);
      else               ewin = (ev == VD) && (eh == 0);
      chk_eq("upd_window", upd_window, ewin);
    end
    while (sb.size() > 0 && sb[0].t < t) begin
      chk_eq("missed_ev_t", sb[0].t, t);
      void'(sb.pop_front());
    end
    if (frame_start) take_ev(1, 0);
    if (upd_ack)     take_ev(3, 0);
    if (line_start)  take_ev(2, line_y);
  endtask

  task automatic step();
    @(posedge clk48);
    if (t % HT == HT - 1 && (t / HT) % VT == VT - 1 && !freeze)
      exp_frame = (exp_frame + 1) % 256;
    t++;
    #2;
    check_cycle();
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  // Asserts reset away from any clock edge, checks the asynchronous return to
  // reset values, then releases and checks the 0,0 cycle.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk_eq("rst_h_count", h_count, 0);
    chk_eq("rst_v_count", v_count, 0);
    chk_eq("rst_hsync", hsync, 1);
    chk_eq("rst_vsync", vsync, 1);
    chk_eq("rst_frame", frame, 0);
    chk_eq("rst_frame_start", frame_start, 0);
    chk_eq("rst_line_start", line_start, 0);
    chk_eq("rst_line_y", line_y, 0);
    chk_eq("rst_upd_window", upd_window, 0);
    chk_eq("rst_upd_ack", upd_ack, 0);
    @(posedge clk48);
    #2;
    rst_n = 1'b1;
    t = 0;
    exp_frame = 0;
    sb.delete();
    check_cycle();
  endtask

  initial begin
    // Two frames without requests, then reset asynchronously mid-line on
    // line 8 of frame 2 while hsync is low.
    win_mode = 0;
    do_reset();
    gen_events(2 * VT + 9, 1'b0);
    run_to((2 * VT + 8) * HT + HD + HFP + 1);
    chk_eq("frame_after_2", frame, 2);
    chk_eq("hsync_low_before_rst", hsync, 0);
    chk_eq("sb_left_p1", sb.size(), 1);

    // Request held from reset: one grant per frame at h=1 of the first vblank line.
    upd_req  = 1'b1;
    win_mode = 1;
    do_reset();
    gen_events(2 * VT + 1, 1'b1);
    run_to((2 * VT + 1) * HT - 1);
    chk_eq("sb_left_p2", sb.size(), 0);
    upd_req = 1'b0;

    // Directed requests: mid-display pulse, request on the close clock,
    // request one clock before the close clock.
    win_mode = 2;
    do_reset();
    gen_events(2 * VT + 1, 1'b0);
    while (t < (2 * VT + 1) * HT - 1) begin
      step();
      if (t == 5 * HT + 10) begin
        chk_eq("win_mid_display", upd_window, 0);
        upd_req = 1'b1;
      end
      if (t == 5 * HT + 11) upd_req = 1'b0;
      if (t == (VT - 1) * HT + LS - 1) begin
        chk_eq("win_at_close", upd_window, 1);
        upd_req = 1'b1;
      end
      if (t == (VT - 1) * HT + LS) begin
        upd_req = 1'b0;
        chk_eq("win_after_close", upd_window, 0);
      end
      if (t == FT + (VT - 1) * HT + LS - 2) begin
        chk_eq("win_before_late_req", upd_window, 1);
        upd_req = 1'b1;
        push_ev(3, t + 1, 0);
      end
      if (t == FT + (VT - 1) * HT + LS - 1) begin
        upd_req = 1'b0;
        chk_eq("win_after_late_ack", upd_window, 0);
      end
    end
    chk_eq("sb_left_p3", sb.size(), 0);

    // One normal frame wrap, then freeze across three more wraps.
    win_mode = 0;
    freeze   = 1'b0;
    do_reset();
    gen_events(4 * VT + 1, 1'b0);
    run_to(FT + 5);
    freeze = 1'b1;
    run_to((4 * VT + 1) * HT - 1);
    chk_eq("frame_frozen", frame, 1);
    chk_eq("sb_left_p4", sb.size(), 0);
    freeze = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
